// File: rtl/rgb_pwm_sink.sv
// rgb_pwm_sink: buffers RGB colour commands in a small FIFO and plays each on an active-low LED via PWM.
// Optional build macro RGB_PWM_GAMMA_EN squares each channel value (c*c >> PWM_BITS) at load time.

module rgb_pwm_sink #(
  parameter int PWM_BITS   = 8,
  parameter int TICK_DIV   = 12000,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PWM_BITS-1:0]  in_r,
  input  logic [PWM_BITS-1:0]  in_g,
  input  logic [PWM_BITS-1:0]  in_b,
  input  logic [HOLD_BITS-1:0] in_hold_ms,
  output logic                 RGB_R,
  output logic                 RGB_G,
  output logic                 RGB_B,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENTRY_W = 3 * PWM_BITS + HOLD_BITS;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [PTR_W:0]     COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHOW} state_t;

  logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  state_t              state_q, state_d;
  logic [2:0][PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [HOLD_BITS-1:0] hold_q, hold_d;
  logic [2:0]          rgb_q, rgb_d;
  logic                frame_done_q, frame_done_d;

  logic                push, pop, full, empty, tick;
  logic [ENTRY_W-1:0]  head;
  logic [PWM_BITS-1:0] head_c    [3];
  logic [PWM_BITS-1:0] head_duty [3];
  logic [HOLD_BITS-1:0] head_hold;

  assign full  = (count_q == COUNT_FULL);
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;
  assign pop   = (state_q == S_LOAD);
  assign tick  = (presc_q == PRESC_MAX);

  // Entries are packed {r, g, b, hold}; channel index 0 is red.
  assign head      = mem_q[rd_ptr_q];
  assign head_hold = head[HOLD_BITS-1:0];

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    assign head_c[gi] = head[HOLD_BITS + (2 - gi) * PWM_BITS +: PWM_BITS];
`ifdef RGB_PWM_GAMMA_EN
    assign head_duty[gi] = PWM_BITS'(({PWM_BITS'(0), head_c[gi]} * {PWM_BITS'(0), head_c[gi]}) >> PWM_BITS);
`else
    assign head_duty[gi] = head_c[gi];
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_r, in_g, in_b, in_hold_ms};
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    duty_d       = duty_q;
    pwm_d        = pwm_q;
    presc_d      = presc_q;
    hold_d       = hold_q;
    rgb_d        = rgb_q;
    frame_done_d = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    case (state_q)
      S_IDLE: begin
        rgb_d = 3'b111;
        if (!empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        // Outputs hold their last value here so back-to-back frames show no dark gap.
        for (int i = 0; i < 3; i++) duty_d[i] = head_duty[i];
        hold_d  = (head_hold == '0) ? HOLD_BITS'(1) : head_hold;
        pwm_d   = '0;
        presc_d = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        pwm_d   = pwm_q + 1'b1;
        presc_d = tick ? '0 : presc_q + 1'b1;
        for (int i = 0; i < 3; i++) rgb_d[i] = ~(pwm_q < duty_q[i]);
        if (tick) begin
          if (hold_q == HOLD_BITS'(1)) begin
            frame_done_d = 1'b1;
            if (empty) begin
              state_d = S_IDLE;
              rgb_d   = 3'b111;
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        rgb_d   = 3'b111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      duty_q       <= '0;
      pwm_q        <= '0;
      presc_q      <= '0;
      hold_q       <= '0;
      rgb_q        <= 3'b111;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      duty_q       <= duty_d;
      pwm_q        <= pwm_d;
      presc_q      <= presc_d;
      hold_q       <= hold_d;
      rgb_q        <= rgb_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = !full;
  assign busy       = (state_q != S_IDLE) || !empty;
  assign frame_done = frame_done_q;
  assign RGB_R      = rgb_q[0];
  assign RGB_G      = rgb_q[1];
  assign RGB_B      = rgb_q[2];

endmodule

// File: doc/rgb_pwm_sink.md
Name: rgb_pwm_sink

Overview:
- Consumer end of an RGB colour stream: accepts colour commands (8-bit R/G/B intensity plus hold time in ms) over a valid/ready handshake.
- Buffers commands in a small FIFO and plays each one in order on the active-low on-board RGB LED.
- Brightness is set by per-channel PWM; each colour is held for its commanded duration.
- Sits between any colour-generating logic (sequencer, UART command decoder) and the RGB_R/RGB_G/RGB_B pins.

Parameters:
- PWM_BITS, 8: PWM counter and duty width; one PWM period = 2^PWM_BITS cycles.
- TICK_DIV, 12000: clk cycles per ms tick (12 MHz clock); sims use 4.
- FIFO_DEPTH, 4: command FIFO entries, power of two, >= 2.
- HOLD_BITS, 16: width of the hold-time field.

Ports:
- clk, input, 1: 12 MHz system clock, single clock domain.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: command present.
- in_ready, output, 1: sink can accept; equals !fifo_full.
- in_r / in_g / in_b, input, PWM_BITS each: channel intensity; 0 = off, max = brightest.
- in_hold_ms, input, HOLD_BITS: display duration in ms.
- RGB_R / RGB_G / RGB_B, output, 1 each: LED drive, active low, registered.
- busy, output, 1: high in LOAD or SHOW, or when the FIFO is non-empty.
- frame_done, output, 1: one-cycle pulse when a command's hold expires.

Behaviour:
- Reset (sampled on a clk edge with rst=1), applied identically mid-operation:
  - FIFO emptied, state=IDLE, all counters 0, duties 0.
  - RGB_R/G/B=1 (all LEDs off), busy=0, frame_done=0.
  - in_ready=1 from the first cycle with rst=0; any in-flight command is discarded.
- Handshake:
  - A command is accepted on an edge where in_valid && in_ready.
  - in_valid while in_ready=0 is ignored; stored entries are never overwritten.
  - Input fields are only sampled on acceptance.
  - Push and pop on the same edge are legal whenever not full; occupancy is then unchanged.
- FSM states:
  - IDLE: outputs forced off (1). Go to LOAD when the FIFO is non-empty.
  - LOAD (exactly 1 cycle):
    - pop the head into the duty_r/g/b registers;
    - hold_cnt <= max(in_hold_ms, 1), so hold 0 behaves as 1 ms;
    - pwm_cnt <= 0, presc <= 0; next state SHOW.
  - SHOW:
    - pwm_cnt free-runs and wraps from 2^PWM_BITS-1 to 0.
    - Each RGB_x <= ~(pwm_cnt < duty_x), so duty 0 means constantly off and duty 255 means on for 255 of every 256 cycles.
    - presc counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps and hold_cnt decrements.
    - Expiry: the tick at which hold_cnt==1 ends the command.
      - frame_done pulses on that edge.
      - Next state is LOAD if the FIFO is non-empty (back-to-back, no dark gap beyond the LOAD cycle), else IDLE.
  - SHOW duration is exactly hold×TICK_DIV cycles.
- Latency:
  - Command accepted on edge E0 with the FIFO empty and state IDLE.
  - State is LOAD after E1 and SHOW after E2.
  - RGB outputs reflect the new duty from E3 onward.
  - During LOAD, the outputs keep their previous values (IDLE → off; back-to-back → last PWM value).
- Widths: all counters are unsigned. presc has clog2(TICK_DIV) bits; hold_cnt has HOLD_BITS bits, with no overflow possible at 0xFFFF.

Optional Feature:
- Macro: RGB_PWM_GAMMA_EN.
- Defined: at LOAD, each duty_x = (c*c) >> PWM_BITS, where c is the popped channel value; the product is computed at full 2×PWM_BITS width. Examples: 255→254, 128→64, 16→1, 15→0.
- Undefined: duty_x = c unchanged. Timing and latency are identical in both builds.

Test Plan (TICK_DIV=4, FIFO_DEPTH=4 unless stated):
1. Reset and single command:
   - Stimulus: hold rst 3 cycles, then push {R=255, G=0, B=128, hold=2}.
   - Response: RGB=111 during reset; after E3, RGB_G constantly 1, RGB_R low 255 of 256 cycles, RGB_B low for the first 128 cycles of each period.
   - frame_done pulses once, 8 cycles after SHOW entry; then IDLE and RGB=111.
2. Full FIFO:
   - Stimulus: with the first command in SHOW and hold=100, push 5 more commands with in_valid held high.
   - Response: 4 accepted (the FIFO fills after the first pops); in_ready=0 while full; the 5th is accepted only after the next pop. Commands play in push order.
3. Back-to-back:
   - Stimulus: push A{0,255,0,1} then B{0,0,255,1}.
   - Response: one frame_done per command; exactly one LOAD cycle between A's last SHOW cycle and B's first.
4. Hold zero:
   - Stimulus: push {hold=0}.
   - Response: SHOW lasts 4 cycles, identical to hold=1.
5. Mid-operation reset:
   - Stimulus: assert rst 1 cycle during SHOW with 3 entries queued.
   - Response: next cycle RGB=111, busy=0, in_ready=1; no further frame_done.
6. RGB_PWM_GAMMA_EN build:
   - Stimulus: push R=128.
   - Response: RGB_R is low for 64 of every 256 cycles; with the macro undefined it is low for 128.
